// File: rtl/hadamard_fp_pkg.sv
// hadamard_fp_pkg
// Shared constants for the hadamard floating-point datapath.
//   expWidth / sigWidth / low_expand : default per-lane field widths
//   SW : signed sum width coming out of the aligned-significand adders
//   P  : bit position of the implicit 1 at the reference exponent
//   OVF / UNF / INX : bit positions inside a lane's 3-bit status field
package hadamard_fp_pkg;

    localparam int expWidth   = 4;
    localparam int sigWidth   = 4;
    localparam int low_expand = 2;

    localparam int SW = sigWidth + 4 + low_expand;
    localparam int P  = sigWidth + low_expand;

    localparam int OVF = 2;
    localparam int UNF = 1;
    localparam int INX = 0;

endpackage

// File: rtl/lod_msb.sv
// lod_msb
// Leading-one detector: returns the index of the most significant set bit.
//   i_data : W-bit operand
//   o_idx  : index of the highest 1 (0 when the operand is zero)
//   o_zero : operand is all zeros
module lod_msb #(
    parameter  int W  = 10,
    localparam int IW = $clog2(W)
) (
    input  logic [W-1:0]  i_data,
    output logic [IW-1:0] o_idx,
    output logic          o_zero
);

    // Scan upward so the highest set bit is the last one to win.
    always_comb begin
        o_idx  = {IW{1'b0}};
        o_zero = (i_data == {W{1'b0}});
        for (int i = 0; i < W; i++) begin
            o_idx = i_data[i] ? IW'(i) : o_idx;
        end
    end

endmodule

// File: rtl/fp_normalizer_2.sv
// fp_normalizer_2
// Two-lane, two-stage normalizer: turns signed aligned-significand sums back
// into packed sign/exponent/significand floats with round-to-nearest-even,
// overflow saturation and underflow flush (exponent 0 means zero only).
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake
//   sum                 : two signed SW-bit sums, lane i at [SW*i +: SW]
//   exp_ref             : reference exponent per lane
//   out_valid/out_ready : output handshake
//   sign_o/exp_o/sig_o  : packed result per lane
//   status              : {ovf,unf,inexact} per lane, only with NORM_STATUS_EN
//
// Optional feature macro: NORM_STATUS_EN adds the status output.
module fp_normalizer_2
    import hadamard_fp_pkg::*;
#(
    parameter  int expWidth   = hadamard_fp_pkg::expWidth,
    parameter  int sigWidth   = hadamard_fp_pkg::sigWidth,
    parameter  int low_expand = hadamard_fp_pkg::low_expand,
    localparam int SW         = sigWidth + 4 + low_expand,
    localparam int P          = sigWidth + low_expand,
    localparam int LW         = $clog2(SW)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*SW-1:0]         sum,
    input  logic [2*expWidth-1:0]   exp_ref,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              sign_o,
    output logic [2*expWidth-1:0]   exp_o,
    output logic [2*sigWidth-1:0]   sig_o
`ifdef NORM_STATUS_EN
    ,
    output logic [3*2-1:0]          status
`endif
);

    localparam int NW = SW + P;   // normalized window below the implicit 1
    localparam logic [LW-1:0] P_IDX = LW'(P);
    localparam logic signed [expWidth+2:0] E_ONE = {{(expWidth+2){1'b0}}, 1'b1};
    localparam logic signed [expWidth+2:0] E_MAX = {3'b000, {expWidth{1'b1}}};

    logic r_run;        // low through reset, keeps in_ready at 0 until released
    logic r_s1_valid;
    logic w_s2_adv;
    logic w_in_acc;

    wire [1:0]              w_sign_nx;
    wire [2*expWidth-1:0]   w_exp_nx;
    wire [2*sigWidth-1:0]   w_sig_nx;
`ifdef NORM_STATUS_EN
    wire [3*2-1:0]          w_stat_nx;
`endif

    assign w_s2_adv = !out_valid || out_ready;
    assign in_ready = r_run && (!r_s1_valid || w_s2_adv);
    assign w_in_acc = in_valid && in_ready;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [SW-1:0]               w_sum;
        logic [SW-1:0]               w_mag;
        logic                        w_sign;
        logic                        w_zero;
        logic [LW-1:0]               w_lead;
        logic signed [expWidth+1:0]  w_epre;

        logic [SW-1:0]               r_mag;
        logic [LW-1:0]               r_lead;
        logic signed [expWidth+1:0]  r_epre;
        logic                        r_sign;
        logic                        r_zero;

        logic [2*SW-1:0]             w_ext;
        logic [NW-1:0]               w_norm;
        logic [sigWidth-1:0]         w_frac;
        logic                        w_guard;
        logic                        w_sticky;
        logic                        w_rup;
        logic [sigWidth:0]           w_rnd;
        logic signed [expWidth+2:0]  w_efin;
        logic                        w_unf;
        logic                        w_ovf;
        logic                        w_sign_l;
        logic [expWidth-1:0]         w_exp_l;
        logic [sigWidth-1:0]         w_sig_l;

        // ---------------- stage 1: magnitude, leading one, exponent -------
        assign w_sum  = sum[SW*g +: SW];
        assign w_sign = w_sum[SW-1];
        // The most-negative sum maps to 2^(SW-1), still representable unsigned.
        assign w_mag  = w_sign ? (~w_sum + {{(SW-1){1'b0}}, 1'b1}) : w_sum;

        lod_msb #(.W(SW)) u_lod (
            .i_data (w_mag),
            .o_idx  (w_lead),
            .o_zero (w_zero)
        );

        assign w_epre = (expWidth+2)'(int'(exp_ref[expWidth*g +: expWidth]) + int'(w_lead) - P);

        // Stage-1 lane registers, loaded on every accepted beat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_mag  <= {SW{1'b0}};
                r_lead <= {LW{1'b0}};
                r_epre <= {(expWidth+2){1'b0}};
                r_sign <= 1'b0;
                r_zero <= 1'b0;
            end else if (w_in_acc) begin
                r_mag  <= w_mag;
                r_lead <= w_lead;
                r_epre <= w_epre;
                r_sign <= w_sign;
                r_zero <= w_zero;
            end else begin
                r_mag  <= r_mag;
                r_lead <= r_lead;
                r_epre <= r_epre;
                r_sign <= r_sign;
                r_zero <= r_zero;
            end
        end

        // ---------------- stage 2: normalize, round, special cases --------
        // The extra SW zero bits below the magnitude keep every bit a right
        // shift pushes out, so sticky sees them without separate logic.
        assign w_ext = {r_mag, {SW{1'b0}}};

        // Move the leading one to position P (bit NW of the extended word).
        always_comb begin
            w_norm = {NW{1'b0}};
            if (r_lead >= P_IDX) begin
                w_norm = NW'(w_ext >> (r_lead - P_IDX));
            end else begin
                w_norm = NW'(w_ext << (P_IDX - r_lead));
            end
        end

        assign w_frac   = w_norm[NW-1 -: sigWidth];
        assign w_guard  = w_norm[NW-1-sigWidth];
        assign w_sticky = |w_norm[NW-2-sigWidth:0];
        assign w_rup    = w_guard && (w_sticky || w_frac[0]);
        // A carry out leaves the low bits at zero, which is the renormalized
        // significand; only the exponent needs the +1.
        assign w_rnd    = {1'b0, w_frac} + {{sigWidth{1'b0}}, w_rup};
        assign w_efin   = $signed({r_epre[expWidth+1], r_epre})
                        + $signed({{(expWidth+2){1'b0}}, w_rnd[sigWidth]});

        assign w_unf = !r_zero && (w_efin < E_ONE);
        assign w_ovf = !r_zero && !w_unf && (w_efin > E_MAX);

        // Special-case priority: zero, then flush, then saturate.
        always_comb begin
            w_sign_l = 1'b0;
            w_exp_l  = {expWidth{1'b0}};
            w_sig_l  = {sigWidth{1'b0}};
            if (r_zero || w_unf) begin
                w_sign_l = 1'b0;
                w_exp_l  = {expWidth{1'b0}};
                w_sig_l  = {sigWidth{1'b0}};
            end else if (w_ovf) begin
                w_sign_l = r_sign;
                w_exp_l  = {expWidth{1'b1}};
                w_sig_l  = {sigWidth{1'b1}};
            end else begin
                w_sign_l = r_sign;
                w_exp_l  = w_efin[expWidth-1:0];
                w_sig_l  = w_rnd[sigWidth-1:0];
            end
        end

        assign w_sign_nx[g]                        = w_sign_l;
        assign w_exp_nx[expWidth*g +: expWidth]    = w_exp_l;
        assign w_sig_nx[sigWidth*g +: sigWidth]    = w_sig_l;
`ifdef NORM_STATUS_EN
        assign w_stat_nx[3*g + OVF] = w_ovf;
        assign w_stat_nx[3*g + UNF] = w_unf;
        assign w_stat_nx[3*g + INX] = !r_zero && !w_unf && (w_guard || w_sticky);
`endif
    end

    // Pipeline valids, run flag and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_s1_valid <= 1'b0;
            out_valid  <= 1'b0;
            sign_o     <= 2'b00;
            exp_o      <= {(2*expWidth){1'b0}};
            sig_o      <= {(2*sigWidth){1'b0}};
`ifdef NORM_STATUS_EN
            status     <= 6'b000000;
`endif
        end else begin
            r_run <= 1'b1;
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end else begin
                r_s1_valid <= r_s1_valid;
            end
            if (w_s2_adv) begin
                out_valid <= r_s1_valid;
            end else begin
                out_valid <= out_valid;
            end
            // Payload only changes when a new beat moves in, so it is held
            // stable through an output stall.
            if (w_s2_adv && r_s1_valid) begin
                sign_o <= w_sign_nx;
                exp_o  <= w_exp_nx;
                sig_o  <= w_sig_nx;
`ifdef NORM_STATUS_EN
                status <= w_stat_nx;
`endif
            end else begin
                sign_o <= sign_o;
                exp_o  <= exp_o;
                sig_o  <= sig_o;
`ifdef NORM_STATUS_EN
                status <= status;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fp_normalizer_2.sv
// tb_fp_normalizer_2
// Directed-vector bench for fp_normalizer_2 at default widths (SW=10, P=6).
// Expected results are hand-computed constants; status is checked when
// NORM_STATUS_EN is defined.
module tb_fp_normalizer_2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] sum;
    logic [7:0]  exp_ref;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  sign_o;
    logic [7:0]  exp_o;
    logic [7:0]  sig_o;
`ifdef NORM_STATUS_EN
    logic [5:0]  status;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fp_normalizer_2 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .exp_ref   (exp_ref),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign_o    (sign_o),
        .exp_o     (exp_o),
        .sig_o     (sig_o)
`ifdef NORM_STATUS_EN
        ,
        .status    (status)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
        end
    endtask

    function automatic logic [8:0] lane(input int i);
        return {sign_o[i], exp_o[4*i +: 4], sig_o[4*i +: 4]};
    endfunction

    // One beat, full-rate output; checks ready, 2-cycle latency and payload.
    task automatic run_vec(input string tag,
                           input logic [9:0] s0, input logic [3:0] e0,
                           input logic [9:0] s1, input logic [3:0] e1,
                           input logic [8:0] x0, input logic [8:0] x1,
                           input logic [5:0] xst);
        @(negedge clk);
        sum       = {s1, s0};
        exp_ref   = {e1, e0};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        check({tag, "_l0"}, 32'(lane(0)), 32'(x0));
        check({tag, "_l1"}, 32'(lane(1)), 32'(x1));
`ifdef NORM_STATUS_EN
        check({tag, "_st"}, 32'(status), 32'(xst));
`else
        if (xst === 6'bxxxxxx) $display("unexpected status argument");
`endif
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : main
        int idx_in;
        int idx_out;
        int inflight;
        logic held;
        logic [8:0] hold0;
        logic [8:0] hold1;
        logic [3:0] pat;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sum       = 20'd0;
        exp_ref   = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_vld",  32'(out_valid), 32'd0);
        check("rst_rdy",  32'(in_ready),  32'd0);
        check("rst_sign", 32'(sign_o),    32'd0);
        check("rst_exp",  32'(exp_o),     32'd0);
        check("rst_sig",  32'(sig_o),     32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // lane1 192: shift right by 1 -> 1.1000 x 2^6
        run_vec("basic", 10'd64, 4'd5, 10'd192, 4'd5, 9'b0_0101_0000, 9'b0_0110_1000, 6'b000_000);
        // -64 keeps sign; 255 rounds up and carries into the exponent
        run_vec("neg",   10'h3C0, 4'd5, 10'd255, 4'd5, 9'b1_0101_0000, 9'b0_0111_0000, 6'b001_000);
        // 66: tie with even lsb stays; 70: tie with odd lsb rounds up
        run_vec("tie",   10'd66, 4'd5, 10'd70, 4'd5, 9'b0_0101_0000, 9'b0_0101_0010, 6'b001_001);
        // exponent 16 saturates; exponent -1 flushes
        run_vec("sat",   10'd192, 4'd15, 10'd16, 4'd1, 9'b0_1111_1111, 9'b0_0000_0000, 6'b010_100);
        // zero sum; most-negative sum -512 -> 1.0000 x 2^6, negative
        run_vec("edge",  10'd0, 4'd9, 10'h200, 4'd3, 9'b0_0000_0000, 9'b1_0110_0000, 6'b000_000);

        // Backpressure: 6 beats against out_ready pattern 1,0,0,1,...
        pat     = 4'b1001;
        idx_in  = 0;
        idx_out = 0;
        held    = 1'b0;
        hold0   = 9'd0;
        hold1   = 9'd0;
        for (int cyc = 0; cyc < 80 && idx_out < 6; cyc++) begin
            @(negedge clk);
            if (held) begin
                check("bp_hold_v", 32'(out_valid), 32'd1);
                check("bp_hold0",  32'(lane(0)),   32'(hold0));
                check("bp_hold1",  32'(lane(1)),   32'(hold1));
            end
            out_ready = pat[cyc % 4];
            in_valid  = (idx_in < 6);
            sum       = {10'd192, 10'd64};
            exp_ref   = {4'(idx_in + 1), 4'(idx_in + 1)};
            #1;
            inflight = idx_in - idx_out;
            check("bp_rdy", 32'(in_ready), 32'(!(inflight == 2 && !out_ready)));
            if (out_valid && out_ready) begin
                check("bp_l0", 32'(lane(0)), 32'({1'b0, 4'(idx_out + 1), 4'b0000}));
                check("bp_l1", 32'(lane(1)), 32'({1'b0, 4'(idx_out + 2), 4'b1000}));
                idx_out++;
            end
            held  = out_valid && !out_ready;
            hold0 = lane(0);
            hold1 = lane(1);
            if (in_valid && in_ready) idx_in++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", 32'(idx_out), 32'd6);

        // Reset with both stages holding a beat.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sum       = {10'd192, 10'd64};
        exp_ref   = {4'd3, 4'd3};
        @(negedge clk);
        sum       = {10'd64, 10'd64};
        exp_ref   = {4'd9, 4'd9};
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_pre_v", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_v",   32'(out_valid), 32'd0);
        check("rst_mid_exp", 32'(exp_o),     32'd0);
        check("rst_mid_sig", 32'(sig_o),     32'd0);
        check("rst_mid_rdy", 32'(in_ready),  32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        run_vec("post", 10'd70, 4'd5, 10'd255, 4'd5, 9'b0_0101_0010, 9'b0_0111_0000, 6'b001_001);
        @(negedge clk);
        check("post_drain", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
